// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the core's data-memory path: tag field layout and
// the flush sequencing states used by the memory-side responder.
package riscv_defs_pkg;

  localparam int TAG_W = 11;

  // Request tag fields, echoed back untouched so the LSU can steer load data
  localparam int TAG_RD_IDX_MSB   = 4;
  localparam int TAG_RD_IDX_LSB   = 0;
  localparam int TAG_ADDR_LSB_MSB = 6;
  localparam int TAG_ADDR_LSB_LSB = 5;
  localparam int TAG_BYTE         = 7;
  localparam int TAG_HALF         = 8;
  localparam int TAG_WORD         = 9;
  localparam int TAG_SIGNED       = 10;

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_DRAIN,
    FLUSH_BUSY,
    FLUSH_RESP
  } flush_state_e;

endpackage

// File: rtl/riscv_dmem_ram.sv
// Single-port synchronous word RAM with byte-lane write enables.
// A read that coincides with a write returns the word as it was before.
module riscv_dmem_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Access the array on enable: update enabled lanes, register the old word
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/riscv_dmem_port.sv
// Memory-side responder for the core's data port: local word RAM with
// fixed-latency in-order acks that echo the request tag, plus a modelled flush.
module riscv_dmem_port
  import riscv_defs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          MEM_WORDS       = 4096,
  parameter int          RD_LATENCY      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          FLUSH_CYCLES    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic             mem_cacheable_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  input  logic             mem_invalidate_i,
  input  logic             mem_flush_i,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [31:0]      mem_data_rd_o,
  output logic [TAG_W-1:0] mem_resp_tag_o
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam int          CW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

  flush_state_e     state_q, state_d;
  logic [CW-1:0]    flushCnt_q, flushCnt_d;
  logic [TAG_W-1:0] flushTag_q, flushTag_d;
  logic [2:0]       outstanding_q;

  logic [RD_LATENCY-1:0] pipeValid_q;
  logic [RD_LATENCY-1:0] pipeRead_q;
  logic [RD_LATENCY-1:0] pipeErr_q;
  logic [TAG_W-1:0]      pipeTag_q  [RD_LATENCY];
  logic [31:0]           pipeData_q [RD_LATENCY];
  logic [31:0]           stageData  [RD_LATENCY];

  logic        anyReq, fire, isFlush, isInv, isWr, isRd, hit, pipeAck, respFlush;
  logic [31:0] offset, ramRdata;
  logic        unusedCacheable;

  assign unusedCacheable = mem_cacheable_i;

  // Decode the winning request type; flush beats invalidate beats write beats read
  assign anyReq  = mem_rd_i | (|mem_wr_i) | mem_invalidate_i | mem_flush_i;
  assign fire    = mem_accept_o & anyReq;
  assign isFlush = mem_flush_i;
  assign isInv   = ~mem_flush_i & mem_invalidate_i;
  assign isWr    = ~mem_flush_i & ~mem_invalidate_i & (|mem_wr_i);
  assign isRd    = ~mem_flush_i & ~mem_invalidate_i & ~(|mem_wr_i) & mem_rd_i;

  assign offset  = mem_addr_i - BASE_ADDR;
  assign hit     = (mem_addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  assign mem_accept_o = (state_q == FLUSH_IDLE) && (outstanding_q < 3'(MAX_OUTSTANDING));
  assign pipeAck      = pipeValid_q[RD_LATENCY-1];
  assign respFlush    = (state_q == FLUSH_RESP);

  riscv_dmem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (fire & (isWr | isRd) & hit),
    .we_i    (isWr ? mem_wr_i : 4'b0000),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (mem_data_wr_i),
    .rdata_o (ramRdata)
  );

  // Read data belongs to stage 0 straight from the RAM, later stages carry a copy
  always_comb begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      stageData[i] = '0;
    end
    stageData[0] = pipeRead_q[0] ? ramRdata : 32'h0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stageData[i] = pipeData_q[i];
    end
  end

  // Response pipeline: every non-flush fire enters stage 0 and acks at the last stage
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pipeValid_q <= '0;
      pipeRead_q  <= '0;
      pipeErr_q   <= '0;
    end else begin
      pipeValid_q[0] <= fire & ~isFlush;
      pipeRead_q[0]  <= fire & isRd & hit;
      pipeErr_q[0]   <= fire & (isWr | isRd) & ~hit;
      pipeTag_q[0]   <= mem_req_tag_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeRead_q[i]  <= pipeRead_q[i-1];
        pipeErr_q[i]   <= pipeErr_q[i-1];
        pipeTag_q[i]   <= pipeTag_q[i-1];
        pipeData_q[i]  <= stageData[i-1];
      end
    end
  end

  // Track accepted-but-unacked requests to throttle accept
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      outstanding_q <= '0;
    end else begin
      case ({fire & ~isFlush, pipeAck})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Flush sequencer registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= FLUSH_IDLE;
      flushCnt_q <= '0;
      flushTag_q <= '0;
    end else begin
      state_q    <= state_d;
      flushCnt_q <= flushCnt_d;
      flushTag_q <= flushTag_d;
    end
  end

  // Flush sequencing: drain in-flight acks, model busy time, then respond once
  always_comb begin
    state_d    = state_q;
    flushCnt_d = flushCnt_q;
    flushTag_d = flushTag_q;
    case (state_q)
      FLUSH_IDLE: begin
        if (fire && isFlush) begin
          state_d    = FLUSH_DRAIN;
          flushTag_d = mem_req_tag_i;
        end
      end
      FLUSH_DRAIN: begin
        if (outstanding_q == 3'd0) begin
          state_d    = FLUSH_BUSY;
          flushCnt_d = CW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH_BUSY: begin
        if (flushCnt_q == '0) begin
          state_d = FLUSH_RESP;
        end else begin
          flushCnt_d = flushCnt_q - 1'b1;
        end
      end
      default: begin
        state_d = FLUSH_IDLE;
      end
    endcase
  end

  // Response outputs are zero unless an ack is being presented
  always_comb begin
    mem_ack_o      = pipeAck | respFlush;
    mem_error_o    = pipeAck & pipeErr_q[RD_LATENCY-1];
    mem_data_rd_o  = pipeAck ? stageData[RD_LATENCY-1] : 32'h0;
    mem_resp_tag_o = '0;
    if (pipeAck) begin
      mem_resp_tag_o = pipeTag_q[RD_LATENCY-1];
    end else if (respFlush) begin
      mem_resp_tag_o = flushTag_q;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_port.sv
// Directed self-checking bench for riscv_dmem_port with default parameters.
module tb_riscv_dmem_port;

  logic        clk;
  logic        rstN;
  logic [31:0] memAddr;
  logic [31:0] memDataWr;
  logic        memRd;
  logic [3:0]  memWr;
  logic        memCacheable;
  logic [10:0] memReqTag;
  logic        memInvalidate;
  logic        memFlush;
  logic        memAccept;
  logic        memAck;
  logic        memError;
  logic [31:0] memDataRd;
  logic [10:0] memRespTag;

  int vectors = 0;
  int miscompares = 0;

  riscv_dmem_port dut (
    .clk_i            (clk),
    .rst_i            (rstN),
    .mem_addr_i       (memAddr),
    .mem_data_wr_i    (memDataWr),
    .mem_rd_i         (memRd),
    .mem_wr_i         (memWr),
    .mem_cacheable_i  (memCacheable),
    .mem_req_tag_i    (memReqTag),
    .mem_invalidate_i (memInvalidate),
    .mem_flush_i      (memFlush),
    .mem_accept_o     (memAccept),
    .mem_ack_o        (memAck),
    .mem_error_o      (memError),
    .mem_data_rd_o    (memDataRd),
    .mem_resp_tag_o   (memRespTag)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleInputs();
    memAddr = '0; memDataWr = '0; memRd = 1'b0; memWr = 4'h0;
    memCacheable = 1'b0; memReqTag = '0; memInvalidate = 1'b0; memFlush = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic [3:0] wr, input logic inv, input logic fl,
                       input logic [31:0] addr, input logic [31:0] data, input logic [10:0] tag);
    memRd = rd; memWr = wr; memInvalidate = inv; memFlush = fl;
    memAddr = addr; memDataWr = data; memReqTag = tag; memCacheable = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    idleInputs();
    repeat (3) @(negedge clk);
    vectors++; if (memAck !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b want 0", memAck); end
    vectors++; if (memError !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b want 0", memError); end
    vectors++; if (memDataRd !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", memDataRd); end
    vectors++; if (memRespTag !== 11'h0) begin miscompares++; $display("[TB] FAIL reset_tag: got %h want 0", memRespTag); end
    vectors++; if (memAccept !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_accept: got %b want 1", memAccept); end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    drive(1'b0, 4'hF, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 11'h000);
    vectors++; if (memAccept !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_accept: got %b want 1", memAccept); end
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h205);
    vectors++; if (memAck !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_early_ack: got %b want 0", memAck); end
    @(negedge clk);
    idleInputs();
    vectors++; if ({memAck, memError} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_ack: ack/err %b%b want 10", memAck, memError); end
    vectors++; if (memRespTag !== 11'h000 || memDataRd !== 32'h0) begin miscompares++; $display("[TB] FAIL wr_ack_tag: tag %h data %h want 000/0", memRespTag, memDataRd); end
    @(negedge clk);
    vectors++; if ({memAck, memError} !== 2'b10) begin miscompares++; $display("[TB] FAIL rd_ack: ack/err %b%b want 10", memAck, memError); end
    vectors++; if (memDataRd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rd_data: got %h want deadbeef", memDataRd); end
    vectors++; if (memRespTag !== 11'h205) begin miscompares++; $display("[TB] FAIL rd_tag: got %h want 205", memRespTag); end
    @(negedge clk);
    vectors++; if (memAck !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ack_pulse: got %b want 0", memAck); end
    @(negedge clk);
  endtask

  task automatic test_byte_write();
    drive(1'b0, 4'b0100, 1'b0, 1'b0, 32'h10, 32'h00AA0000, 11'h001);
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h002);
    @(negedge clk);
    idleInputs();
    vectors++; if (memAck !== 1'b1 || memRespTag !== 11'h001) begin miscompares++; $display("[TB] FAIL bw_ack: ack %b tag %h want 1/001", memAck, memRespTag); end
    @(negedge clk);
    vectors++; if (memDataRd !== 32'hDEAABEEF || memRespTag !== 11'h002) begin miscompares++; $display("[TB] FAIL bw_data: data %h tag %h want deaabeef/002", memDataRd, memRespTag); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss();
    drive(1'b0, 4'hF, 1'b0, 1'b0, 32'h4010, 32'h12345678, 11'h003);
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h4000, 32'h0, 11'h155);
    @(negedge clk);
    idleInputs();
    vectors++; if ({memAck, memError} !== 2'b11 || memRespTag !== 11'h003) begin miscompares++; $display("[TB] FAIL miss_wr: ack/err %b%b tag %h want 11/003", memAck, memError, memRespTag); end
    @(negedge clk);
    vectors++; if ({memAck, memError} !== 2'b11 || memRespTag !== 11'h155) begin miscompares++; $display("[TB] FAIL miss_rd: ack/err %b%b tag %h want 11/155", memAck, memError, memRespTag); end
    vectors++; if (memDataRd !== 32'h0) begin miscompares++; $display("[TB] FAIL miss_rd_data: got %h want 0", memDataRd); end
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h156);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    vectors++; if (memDataRd !== 32'hDEAABEEF || memError !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_no_alias: data %h err %b want deaabeef/0", memDataRd, memError); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    drive(1'b0, 4'hF, 1'b1, 1'b0, 32'h10, 32'h0, 11'h010);
    @(negedge clk);
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 32'h10, 32'h00000011, 11'h011);
    @(negedge clk);
    idleInputs();
    vectors++; if (memAck !== 1'b1 || memError !== 1'b0 || memDataRd !== 32'h0 || memRespTag !== 11'h010) begin
      miscompares++; $display("[TB] FAIL inv_ack: ack %b err %b data %h tag %h want 1/0/0/010", memAck, memError, memDataRd, memRespTag); end
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h012);
    vectors++; if (memAck !== 1'b1 || memDataRd !== 32'h0 || memRespTag !== 11'h011) begin
      miscompares++; $display("[TB] FAIL rdwr_is_write: ack %b data %h tag %h want 1/0/011", memAck, memDataRd, memRespTag); end
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    vectors++; if (memDataRd !== 32'hDEAABE11 || memRespTag !== 11'h012) begin
      miscompares++; $display("[TB] FAIL prio_readback: data %h tag %h want deaabe11/012", memDataRd, memRespTag); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int fireCyc[$];
    logic [10:0] fireTag[$];
    logic [10:0] nextTag = 11'h100;
    for (int k = 0; k < 10; k++) begin
      int cnt = 0;
      int ackIdx = -1;
      logic expAccept;
      foreach (fireCyc[j]) begin
        if (fireCyc[j] < k && fireCyc[j] + 2 >= k) cnt++;
        if (fireCyc[j] + 2 == k) ackIdx = j;
      end
      expAccept = (cnt < 2);
      vectors++; if (memAccept !== expAccept) begin miscompares++; $display("[TB] FAIL b2b_accept c%0d: got %b want %b", k, memAccept, expAccept); end
      if (ackIdx >= 0) begin
        vectors++; if (memAck !== 1'b1 || memRespTag !== fireTag[ackIdx] || memDataRd !== 32'hDEAABE11) begin
          miscompares++; $display("[TB] FAIL b2b_ack c%0d: ack %b tag %h data %h want 1/%h/deaabe11", k, memAck, memRespTag, memDataRd, fireTag[ackIdx]); end
      end else begin
        vectors++; if (memAck !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_noack c%0d: got %b want 0", k, memAck); end
      end
      if (k < 6) begin
        drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, nextTag);
        if (expAccept) begin
          fireCyc.push_back(k);
          fireTag.push_back(nextTag);
          nextTag = nextTag + 11'h1;
        end
      end else begin
        idleInputs();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h001);
    vectors++; if (memAccept !== 1'b1) begin miscompares++; $display("[TB] FAIL fl_rd1_accept: got %b want 1", memAccept); end
    @(negedge clk);
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h002);
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h0, 11'h7FF);
    vectors++; if (memAccept !== 1'b0 || memAck !== 1'b1 || memRespTag !== 11'h001) begin
      miscompares++; $display("[TB] FAIL fl_c2: accept %b ack %b tag %h want 0/1/001", memAccept, memAck, memRespTag); end
    @(negedge clk);
    vectors++; if (memAccept !== 1'b1 || memAck !== 1'b1 || memRespTag !== 11'h002) begin
      miscompares++; $display("[TB] FAIL fl_c3: accept %b ack %b tag %h want 1/1/002", memAccept, memAck, memRespTag); end
    @(negedge clk);
    idleInputs();
    for (int c = 4; c <= 12; c++) begin
      vectors++; if (memAccept !== 1'b0 || memAck !== 1'b0) begin
        miscompares++; $display("[TB] FAIL fl_busy c%0d: accept %b ack %b want 0/0", c, memAccept, memAck); end
      @(negedge clk);
    end
    vectors++; if (memAck !== 1'b1 || memError !== 1'b0 || memDataRd !== 32'h0 || memRespTag !== 11'h7FF || memAccept !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fl_resp: ack %b err %b data %h tag %h accept %b want 1/0/0/7ff/0", memAck, memError, memDataRd, memRespTag, memAccept); end
    @(negedge clk);
    vectors++; if (memAccept !== 1'b1 || memAck !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fl_done: accept %b ack %b want 1/0", memAccept, memAck); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_busy();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h0, 11'h3AA);
    vectors++; if (memAccept !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_accept: got %b want 1", memAccept); end
    @(negedge clk);
    idleInputs();
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    vectors++; if (memAck !== 1'b0 || memError !== 1'b0 || memDataRd !== 32'h0 || memRespTag !== 11'h0) begin
      miscompares++; $display("[TB] FAIL rb_outputs: ack %b err %b data %h tag %h want all 0", memAck, memError, memDataRd, memRespTag); end
    vectors++; if (memAccept !== 1'b1) begin miscompares++; $display("[TB] FAIL rb_accept_after: got %b want 1", memAccept); end
    drive(1'b1, 4'h0, 1'b0, 1'b0, 32'h10, 32'h0, 11'h0AB);
    @(negedge clk);
    idleInputs();
    @(negedge clk);
    vectors++; if (memAck !== 1'b1 || memDataRd !== 32'hDEAABE11 || memRespTag !== 11'h0AB) begin
      miscompares++; $display("[TB] FAIL rb_read: ack %b data %h tag %h want 1/deaabe11/0ab", memAck, memDataRd, memRespTag); end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      vectors++; if (memAck !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rb_stray_ack c%0d: ack %b tag %h want 0", c, memAck, memRespTag); end
    end
  endtask

  // Scenario sequence
  initial begin
    rstN = 1'b0;
    idleInputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_byte_write();
    test_miss();
    test_priority();
    test_back_to_back();
    test_flush();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_port.md
Name: riscv_dmem_port

Overview:
Memory-side responder for the core's data-memory request interface: the target that the load/store unit issues reads, byte-enabled writes, invalidates and flushes to. It holds a word-addressed local data RAM and accepts at most one request per cycle. It returns in-order, fixed-latency acks that echo the request tag, so the initiator can steer load data to the right writeback register. It sits between the core's data port and local TCM, and doubles as the bench memory model for the core.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of RAM word 0
MEM_WORDS, 4096, RAM depth in 32-bit words (power of two)
RD_LATENCY, 2, cycles from request accept to ack (legal 1..4)
MAX_OUTSTANDING, 2, max accepted-but-unacked requests (legal 1..RD_LATENCY)
FLUSH_CYCLES, 8, busy cycles modelled for a flush (legal >=1)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-low
mem_addr_i  in  32  word-aligned byte address, bits [1:0] ignored
mem_data_wr_i  in  32  write data, lane-aligned
mem_rd_i  in  1  read request
mem_wr_i  in  4  byte-lane write enables
mem_cacheable_i  in  1  attribute, ignored (accepted for interface completeness)
mem_req_tag_i  in  11  request tag, echoed on ack
mem_invalidate_i  in  1  invalidate request
mem_flush_i  in  1  flush request
mem_accept_o  out  1  request accepted this cycle if any request input high
mem_ack_o  out  1  response valid, one cycle pulse, no backpressure
mem_error_o  out  1  response error, qualified by mem_ack_o
mem_data_rd_o  out  32  read data, qualified by mem_ack_o, else 0
mem_resp_tag_o  out  11  echoed tag, qualified by mem_ack_o, else 0

Behaviour:
- Reset (rst_i==0 at clock edge): all outputs 0, pipeline valids cleared, outstanding count 0, FSM IDLE. RAM contents not reset. Reset mid-flush aborts: no ack.
- mem_accept_o = (state==IDLE) && (outstanding < MAX_OUTSTANDING). Combinational from state only, never from request inputs.
- Fire = mem_accept_o && (mem_rd_i || |mem_wr_i || mem_invalidate_i || mem_flush_i).
- Priority when several inputs are high: flush > invalidate > write > read. Exactly one ack per fire.
- Range check: hit = BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS. Index = (addr - BASE_ADDR)[log2(MEM_WORDS)+1:2].
- Write fire: if hit, the enabled byte lanes are written at the fire edge. A miss writes nothing and returns error=1. Ack data is 0.
- Read fire: RAM is read synchronously. Ack data = RAM word, or 0 with error=1 on a miss.
- Write visibility: a write at cycle T is visible to a read fired at T+1 or later.
- Invalidate fire: no RAM effect. Ack with error=0 and data=0.
- Pipeline: RD_LATENCY-stage shift register carrying valid, tag, error and RAM index/data. A request fired in cycle T acks in cycle T+RD_LATENCY. Acks are strictly in order.
- Outstanding counter: +1 on fire (excluding flush), -1 on pipeline ack. Both in the same cycle leave it unchanged. It never exceeds MAX_OUTSTANDING.
- FSM (flush only):
  - IDLE --flush fire--> DRAIN. The flush tag is latched.
  - DRAIN --outstanding==0--> BUSY. The counter is loaded with FLUSH_CYCLES-1.
  - BUSY --counter==0--> RESP. Otherwise the counter decrements.
  - RESP: ack with flush tag, error=0, data=0 for one cycle, then back to IDLE.
  - mem_accept_o is low in DRAIN, BUSY and RESP, so the flush ack never collides with a pipeline ack.
- Both mem_rd_i and mem_wr_i high on one fire: treated as a write only.

Decomposition:
- Shared package riscv_defs_pkg gains:
  - tag field constants: RD_IDX [4:0], ADDR_LSB [6:5], BYTE 7, HALF 8, WORD 9, SIGNED 10;
  - the flush FSM state enum.
- One sub-module, riscv_dmem_ram: single-port synchronous RAM, 32-bit word, 4 byte-lane write enables, read-during-write returns old data. The port logic guarantees ordering.

Test Plan:
1. Reset deasserts; in cycle 5 write addr 0x10, wr=4'hF, data 0xDEADBEEF, tag 0; in cycle 6 read addr 0x10, tag 0x205 -> ack for the write at cycle 7 with error=0; ack for the read at cycle 8 with data 0xDEADBEEF and tag 0x205.
2. Byte write addr 0x10, wr=4'b0100, data 0x00AA0000, then read 0x10 -> data 0xDEADBEEF with lane 2 replaced, i.e. 0xDEAABEEF.
3. Read addr BASE_ADDR+0x4000 (MEM_WORDS=4096) -> ack after 2 cycles with error=1, data 0, tag echoed; RAM unchanged.
4. Hold mem_rd_i high for 6 cycles with incrementing tags -> accept low whenever 2 requests are outstanding; acks in tag order, each 2 cycles after its fire; counter never exceeds 2.
5. Two reads in flight, then a flush with tag 0x7FF -> accept low; the two reads ack; then 8 BUSY cycles; then a single ack with tag 0x7FF; accept high the next cycle.
6. rst_i low for 1 cycle during BUSY -> all outputs 0 the next cycle; no flush ack ever; accept high after rst_i returns high.
